// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: sprite-sheet ROM port; the compositor drives the address, the ROM returns data one clock later
interface sprite_compositor_if #(
    parameter int ROM_AW = 17,
    parameter int IDX_W  = 8
);
    logic [ROM_AW-1:0] oROM_ADDR;
    logic [IDX_W-1:0]  iROM_DATA;
    modport master (output oROM_ADDR, input iROM_DATA);
    modport slave  (input oROM_ADDR, output iROM_DATA);
endinterface

// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel priority compositing of frame-latched sprites into a palette index stream
module sprite_compositor #(
    parameter int N_SPRITES              = 6,
    parameter int H_ACTIVE               = 640,
    parameter int V_ACTIVE               = 480,
    parameter int COORD_W                = 10,
    parameter int ROM_AW                 = 17,
    parameter int ROM_STRIDE             = 640,
    parameter int IDX_W                  = 8,
    parameter logic [IDX_W-1:0] TRANSP_IDX = 8'hFF,
    parameter logic [IDX_W-1:0] BG_IDX     = 8'h00
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic                          iHS,
    input  logic                          iVS,
    input  logic                          iBLANK_n,
    input  logic [N_SPRITES*COORD_W-1:0]  sprite_x,
    input  logic [N_SPRITES*COORD_W-1:0]  sprite_y,
    input  logic [N_SPRITES*COORD_W-1:0]  sprite_w,
    input  logic [N_SPRITES*COORD_W-1:0]  sprite_h,
    input  logic [N_SPRITES*ROM_AW-1:0]   sprite_base,
    input  logic [N_SPRITES-1:0]          sprite_en,
    sprite_compositor_if.master           rom,
    output logic [IDX_W-1:0]              oINDEX,
    output logic                          oHS,
    output logic                          oVS,
    output logic                          oBLANK_n,
    output logic                          oCOLLIDE
);
    localparam int SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [COORD_W-1:0] HMAX   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VMAX   = COORD_W'(V_ACTIVE);
    localparam logic [ROM_AW-1:0]  STRIDE = ROM_AW'(ROM_STRIDE);

    logic [N_SPRITES*COORD_W-1:0] r_sx, r_sy, r_sw, r_sh;
    logic [N_SPRITES*ROM_AW-1:0]  r_sb;
    logic [N_SPRITES-1:0]         r_se;
    logic [COORD_W-1:0]           r_hcnt, r_vcnt;
    logic [2:0]                   r_hs_d, r_vs_d, r_bl_d;
    logic                         r_sticky, r_collide, r_v1, r_v2;
    logic [ROM_AW-1:0]            r_addr;
    logic [IDX_W-1:0]             r_index;

    logic [N_SPRITES-1:0] w_hit;
    logic [SEL_W-1:0]     w_sel;
    logic [ROM_AW-1:0]    w_dx, w_dy, w_addr;
    logic                 w_vs_fall, w_bl_fall, w_valid, w_coll;

    assign w_vs_fall = r_vs_d[0] & ~iVS;
    assign w_bl_fall = r_bl_d[0] & ~iBLANK_n;

    // Half-open box test per slot; sums carry one extra bit so boxes near the coordinate limit cannot wrap
    for (genvar k = 0; k < N_SPRITES; k++) begin : g_slot
        logic [COORD_W-1:0] w_x, w_y, w_w, w_h;
        assign w_x = r_sx[k*COORD_W +: COORD_W];
        assign w_y = r_sy[k*COORD_W +: COORD_W];
        assign w_w = r_sw[k*COORD_W +: COORD_W];
        assign w_h = r_sh[k*COORD_W +: COORD_W];
        assign w_hit[k] = r_se[k] &&
                          (r_hcnt >= w_x) && ({1'b0, r_hcnt} < {1'b0, w_x} + {1'b0, w_w}) &&
                          (r_vcnt >= w_y) && ({1'b0, r_vcnt} < {1'b0, w_y} + {1'b0, w_h});
    end

    // Lowest-index hitting slot wins; only its texel is fetched
    always_comb begin
        w_sel = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--)
            if (w_hit[i]) w_sel = SEL_W'(i);
    end

    assign w_dx    = ROM_AW'(r_hcnt - r_sx[w_sel*COORD_W +: COORD_W]);
    assign w_dy    = ROM_AW'(r_vcnt - r_sy[w_sel*COORD_W +: COORD_W]);
    assign w_addr  = r_sb[w_sel*ROM_AW +: ROM_AW] + w_dy * STRIDE + w_dx;
    assign w_valid = iBLANK_n && (|w_hit);
    assign w_coll  = iBLANK_n && w_hit[0] && (|(w_hit >> 1));

    // Shadow the sprite table at VS fall and hand the frame's collision result to the game logic
    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) begin
            r_sx      <= '0;
            r_sy      <= '0;
            r_sw      <= '0;
            r_sh      <= '0;
            r_sb      <= '0;
            r_se      <= '0;
            r_sticky  <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            if (w_vs_fall) begin
                r_sx      <= sprite_x;
                r_sy      <= sprite_y;
                r_sw      <= sprite_w;
                r_sh      <= sprite_h;
                r_sb      <= sprite_base;
                r_se      <= sprite_en;
                r_collide <= r_sticky;
            end
            r_sticky <= w_vs_fall ? w_coll : (r_sticky | w_coll);
        end

    // Pixel position; saturating at the active size keeps malformed timing from wrapping into visible boxes
    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!iVS) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (iBLANK_n) begin
            r_hcnt <= (r_hcnt == HMAX) ? r_hcnt : r_hcnt + 1'b1;
        end else if (w_bl_fall) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == VMAX) ? r_vcnt : r_vcnt + 1'b1;
        end

    // Fetch, wait one clock for the ROM, then resolve transparency into the output index
    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) begin
            r_addr  <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_index <= BG_IDX;
        end else begin
            if (w_valid) r_addr <= w_addr;
            r_v1    <= w_valid;
            r_v2    <= r_v1;
            r_index <= (r_v2 && rom.iROM_DATA != TRANSP_IDX) ? rom.iROM_DATA : BG_IDX;
        end

    // Delay sync and blank by the pipeline depth; stage 0 doubles as the edge detector history
    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) begin
            r_hs_d <= 3'b111;
            r_vs_d <= 3'b111;
            r_bl_d <= 3'b000;
        end else begin
            r_hs_d <= {r_hs_d[1:0], iHS};
            r_vs_d <= {r_vs_d[1:0], iVS};
            r_bl_d <= {r_bl_d[1:0], iBLANK_n};
        end

    assign rom.oROM_ADDR = r_addr;
    assign oINDEX        = r_index;
    assign oHS           = r_hs_d[2];
    assign oVS           = r_vs_d[2];
    assign oBLANK_n      = r_bl_d[2];
    assign oCOLLIDE      = r_collide;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: randomized and directed frames checked against a per-pixel reference of the compositing rules
module tb_sprite_compositor;
    localparam int N      = 6;
    localparam int CW     = 10;
    localparam int AW     = 17;
    localparam int HA     = 64;
    localparam int HB     = 8;
    localparam int VA     = 24;
    localparam int STRIDE = 640;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic hs = 1'b1, vs = 1'b1, bl = 1'b0;
    logic [N*CW-1:0] sx_v, sy_v, sw_v, sh_v;
    logic [N*AW-1:0] sb_v;
    logic [N-1:0]    se_v;
    logic [7:0]      idx;
    logic            ohs, ovs, obl, ocol;

    int cx[N], cy[N], cw[N], chh[N], cb[N];
    bit ce[N];
    int mx[N], my[N], mw[N], mh[N], mb[N];
    bit me[N];

    logic [AW-1:0] e_addr;
    bit            e_col, m_sticky, prev_vs;
    logic [10:0]   q[$];
    int            n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_cfg
        assign sx_v[k*CW +: CW] = CW'(cx[k]);
        assign sy_v[k*CW +: CW] = CW'(cy[k]);
        assign sw_v[k*CW +: CW] = CW'(cw[k]);
        assign sh_v[k*CW +: CW] = CW'(chh[k]);
        assign sb_v[k*AW +: AW] = AW'(cb[k]);
        assign se_v[k]          = ce[k];
    end

    sprite_compositor_if #(.ROM_AW(AW), .IDX_W(8)) rom_if();

    function automatic logic [7:0] romf(logic [AW-1:0] a);
        return a[AW-1] ? 8'hFF : a[7:0];
    endfunction

    always @(posedge clk) rom_if.iROM_DATA <= romf(rom_if.oROM_ADDR);

    sprite_compositor #(
        .N_SPRITES(N), .H_ACTIVE(HA), .V_ACTIVE(VA), .COORD_W(CW),
        .ROM_AW(AW), .ROM_STRIDE(STRIDE), .IDX_W(8),
        .TRANSP_IDX(8'hFF), .BG_IDX(8'h00)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .iHS(hs), .iVS(vs), .iBLANK_n(bl),
        .sprite_x(sx_v), .sprite_y(sy_v), .sprite_w(sw_v), .sprite_h(sh_v),
        .sprite_base(sb_v), .sprite_en(se_v),
        .rom(rom_if.master),
        .oINDEX(idx), .oHS(ohs), .oVS(ovs), .oBLANK_n(obl), .oCOLLIDE(ocol)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mhit(int k, int h, int v);
        return me[k] && h >= mx[k] && h < mx[k] + mw[k] && v >= my[k] && v < my[k] + mh[k];
    endfunction

    task automatic set(int k, int x, int y, int w, int h, int b, bit e);
        cx[k] = x; cy[k] = y; cw[k] = w; chh[k] = h; cb[k] = b; ce[k] = e;
    endtask

    task automatic clear();
        for (int k = 0; k < N; k++) set(k, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_addr", 32'(rom_if.oROM_ADDR), 0);
        check("rst_index", 32'(idx), 0);
        check("rst_sync", 32'({ohs, ovs, obl}), 32'b110);
        check("rst_collide", 32'(ocol), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            mx[k] = 0; my[k] = 0; mw[k] = 0; mh[k] = 0; mb[k] = 0; me[k] = 1'b0;
        end
        e_addr = '0; e_col = 1'b0; m_sticky = 1'b0; prev_vs = 1'b1;
        q = {11'b110_0000_0000, 11'b110_0000_0000};
    endtask

    task automatic cyc(bit h_s, bit v_s, bit b, int h, int v);
        int w;
        bit col;
        logic [7:0] e_idx;
        logic [AW-1:0] a;
        logic [10:0] ex;
        hs = h_s; vs = v_s; bl = b;
        w = -1; col = 1'b0; e_idx = 8'h00;
        if (b) begin
            for (int k = N - 1; k >= 0; k--) if (mhit(k, h, v)) w = k;
            for (int k = 1; k < N; k++) if (mhit(0, h, v) && mhit(k, h, v)) col = 1'b1;
        end
        if (w >= 0) begin
            a = AW'(mb[w] + (v - my[w]) * STRIDE + (h - mx[w]));
            e_addr = a;
            if (romf(a) != 8'hFF) e_idx = romf(a);
        end
        if (!v_s && prev_vs) begin
            e_col = m_sticky;
            m_sticky = col;
            for (int k = 0; k < N; k++) begin
                mx[k] = cx[k]; my[k] = cy[k]; mw[k] = cw[k]; mh[k] = chh[k]; mb[k] = cb[k]; me[k] = ce[k];
            end
        end else m_sticky = m_sticky | col;
        prev_vs = v_s;
        q.push_back({h_s, v_s, b, e_idx});
        @(posedge clk);
        #1;
        check("rom_addr", 32'(rom_if.oROM_ADDR), 32'(e_addr));
        check("collide", 32'(ocol), 32'(e_col));
        ex = q.pop_front();
        check("sync", 32'({ohs, ovs, obl}), 32'(ex[10:8]));
        check("index", 32'(idx), 32'(ex[7:0]));
    endtask

    task automatic run_frame(int mid_line = -1, int mid_slot = 0, int ny = 0, int rst_line = -1);
        for (int l = 0; l < 4 + VA + 1; l++)
            for (int c = 0; c < HA + HB; c++) begin
                bit act;
                act = (l >= 4) && (l < 4 + VA) && (c < HA);
                if (l == mid_line && c == 0) cy[mid_slot] = ny;
                if (l == rst_line && c == 20) do_reset();
                cyc(!(c >= HA + 2 && c < HA + 6), l >= 2, act, c, l - 4);
            end
    endtask

    initial begin
        clear();
        #3;
        do_reset();
        set(0, 20, 5, 13, 9, 0, 1'b1);
        run_frame();
        clear();
        set(0, 8, 3, 10, 6, 'h10000, 1'b1);
        set(1, 8, 3, 10, 6, 'h100, 1'b1);
        run_frame();
        clear();
        set(2, 60, 10, 54, 4, 'h200, 1'b1);
        run_frame();
        clear();
        set(0, 20, 5, 13, 9, 0, 1'b1);
        run_frame(10, 0, 12);
        run_frame();
        clear();
        set(0, 10, 10, 5, 5, 'h300, 1'b1);
        set(1, 14, 14, 3, 3, 'h400, 1'b1);
        run_frame();
        set(1, 30, 14, 3, 3, 'h400, 1'b1);
        run_frame();
        run_frame();
        clear();
        set(0, 20, 5, 13, 9, 0, 1'b1);
        set(3, 2, 2, 30, 20, 'h500, 1'b1);
        run_frame();
        run_frame(-1, 0, 0, 14);
        run_frame();
        repeat (6) begin
            for (int k = 0; k < N; k++)
                set(k, $urandom_range(0, 75), $urandom_range(0, 28), $urandom_range(0, 20),
                    $urandom_range(0, 12), $urandom_range(0, 'h1FFFF), 1'($urandom_range(0, 1)));
            run_frame($urandom_range(4, 27), $urandom_range(0, N - 1), $urandom_range(0, 28));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
